// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file.
// Holds the clear-sequencer state encoding, the default parameter values
// used by regfile_param and its sub-module, and a helper that sizes the
// clear pointer and physical index.
package regfile_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 3;
    localparam int DEF_BASE_ID  = 5;
    localparam int DEF_ID_W     = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_e;

    // A single-register file still needs a 1-bit pointer to stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer for regfile_param.
// Walks a pointer from 0 to NUM_REGS-1, one register per cycle, after a
// clear request seen in IDLE. Requests while already clearing are ignored.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   clear_req   - single-cycle request to start zeroing the file
//   busy        - high while the sequence runs (exactly NUM_REGS cycles)
//   clear_ptr   - physical register zeroed at the end of the current cycle
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int PTR_W    = ptr_width(DEF_NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_req,
    output logic             busy,
    output logic [PTR_W-1:0] clear_ptr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_REGS - 1);

    clear_state_e     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                // The last register is zeroed in the same cycle we leave.
                if (ptr_q == LAST_PTR) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = '0;
            end
        endcase
    end

    assign clear_ptr = ptr_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with an offset id space.
// Architectural ids BASE_ID .. BASE_ID+NUM_REGS-1 map onto physical
// registers 0 .. NUM_REGS-1; any other id is invalid (reads 0, writes are
// rejected). Two combinational read ports with write bypass, one write
// port, and a multi-cycle clear sequence run by regfile_clear_fsm.
// Ports:
//   clk, reset                 - clock and asynchronous active-high reset
//   write_enable, reg_id_d,
//   reg_d_value                - write request, destination id, data
//   reg_id_a / reg_id_b        - read ids
//   reg_a_value / reg_b_value  - read data
//   clear_req                  - start zeroing the whole file
//   busy                       - clear sequence in progress
//   write_err                  - one-cycle pulse after a rejected write
module regfile_param
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BASE_ID  = DEF_BASE_ID,
    parameter int ID_W     = DEF_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [ID_W-1:0]  reg_id_d,
    input  logic [WIDTH-1:0] reg_d_value,
    input  logic [ID_W-1:0]  reg_id_a,
    input  logic [ID_W-1:0]  reg_id_b,
    output logic [WIDTH-1:0] reg_a_value,
    output logic [WIDTH-1:0] reg_b_value,
    input  logic             clear_req,
    output logic             busy,
    output logic             write_err
);

    localparam int PTR_W = ptr_width(NUM_REGS);

    // One extra bit so ids below BASE_ID cannot wrap into the valid range.
    localparam logic [ID_W:0] BASE_EXT = (ID_W + 1)'(BASE_ID);
    localparam logic [ID_W:0] NUM_EXT  = (ID_W + 1)'(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];

    logic [PTR_W-1:0] clear_ptr;
    logic             write_ok;

    logic [ID_W:0]    diff_d, diff_a, diff_b;
    logic             valid_d, valid_a, valid_b;
    logic [PTR_W-1:0] idx_d, idx_a, idx_b;

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .PTR_W    (PTR_W)
    ) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clear_ptr (clear_ptr)
    );

    always_comb begin
        diff_d  = {1'b0, reg_id_d} - BASE_EXT;
        diff_a  = {1'b0, reg_id_a} - BASE_EXT;
        diff_b  = {1'b0, reg_id_b} - BASE_EXT;
        valid_d = ({1'b0, reg_id_d} >= BASE_EXT) && (diff_d < NUM_EXT);
        valid_a = ({1'b0, reg_id_a} >= BASE_EXT) && (diff_a < NUM_EXT);
        valid_b = ({1'b0, reg_id_b} >= BASE_EXT) && (diff_b < NUM_EXT);
        idx_d   = diff_d[PTR_W-1:0];
        idx_a   = diff_a[PTR_W-1:0];
        idx_b   = diff_b[PTR_W-1:0];
    end

    assign write_ok = write_enable && valid_d && !busy;

    // Clear and write never coincide: a write is only accepted when not busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (busy) begin
            regs[clear_ptr] <= '0;
        end else if (write_ok) begin
            regs[idx_d] <= reg_d_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_err <= 1'b0;
        end else begin
            write_err <= write_enable && !write_ok;
        end
    end

    // An accepted write implies a valid destination, so a matching read id
    // is valid too and the bypass can take priority over the array.
    always_comb begin
        reg_a_value = '0;
        reg_b_value = '0;
        if (valid_a) begin
            reg_a_value = (write_ok && (reg_id_a == reg_id_d)) ? reg_d_value : regs[idx_a];
        end
        if (valid_b) begin
            reg_b_value = (write_ok && (reg_id_b == reg_id_d)) ? reg_d_value : regs[idx_b];
        end
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 32: data width of every register and data port.
REQ-002 Parameter NUM_REGS, default 3: number of physical registers; legal range 1..2**ID_W - BASE_ID.
REQ-003 Parameter BASE_ID, default 5: architectural id mapped to physical register 0.
REQ-004 Parameter ID_W, default 5: width of every register-id port.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 write_enable  input  1  write request for the current cycle.
REQ-008 reg_id_d  input  ID_W  destination architectural id.
REQ-009 reg_d_value  input  WIDTH  write data.
REQ-010 reg_id_a / reg_id_b  input  ID_W  read-port A and B architectural ids.
REQ-011 reg_a_value / reg_b_value  output  WIDTH  read-port A and B data.
REQ-012 clear_req  input  1  single-cycle request to zero the whole file.
REQ-013 busy  output  1  high while the clear sequence runs.
REQ-014 write_err  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-015 Index = id - BASE_ID, computed in ID_W+1 bits; the id is valid only when BASE_ID <= id < BASE_ID+NUM_REGS; no modulo wrap (id < BASE_ID is invalid, never aliased).
REQ-016 A write is accepted when write_enable=1, reg_id_d is valid and busy=0; the register updates at the next posedge.
REQ-017 Reads are combinational: valid id returns the stored value; invalid id returns 0.
REQ-018 Bypass: when an accepted write targets the same id as a read port in the same cycle, that port returns reg_d_value in that cycle.
REQ-019 Rejected write (write_enable=1 with invalid id, or with busy=1): storage unchanged; write_err=1 for exactly the following cycle; otherwise write_err=0.
REQ-020 FSM states IDLE, CLEAR; IDLE->CLEAR on clear_req=1; clear pointer starts at 0, zeroes one register per cycle, increments by 1.
REQ-021 CLEAR->IDLE in the cycle the register at pointer NUM_REGS-1 is zeroed; busy=1 exactly NUM_REGS cycles, beginning the cycle after clear_req.
REQ-022 clear_req while busy=1 is ignored; there is no restart and no pointer reset.
REQ-023 During CLEAR, reads return current contents (already-cleared entries read 0); bypass is inactive because no write is accepted.
REQ-024 clear_req and write_enable in the same IDLE cycle: the write is accepted, then the clear sequence zeroes it.

Reset
REQ-025 reset=1 immediately forces all registers to 0, state IDLE, pointer 0, busy=0, write_err=0, independent of clk.
REQ-026 reset asserted mid-clear aborts the sequence; after release the block is IDLE with all registers 0.

Structure
REQ-027 Shared package regfile_pkg holds the FSM state enum and default parameter constants (WIDTH, NUM_REGS, BASE_ID, ID_W).
REQ-028 One sub-module, regfile_clear_fsm, owns the state, pointer and busy; the storage array, decode, bypass and write_err stay in regfile_param.

Verification
REQ-029 Defaults; write id 6 value 0xDEADBEEF with reg_id_b=6 -> reg_b_value=0xDEADBEEF in the same cycle and in the following cycle.
REQ-030 Write id 4, then id 8 -> write_err pulses one cycle after each; reads of ids 5..7 unchanged; reads of ids 4 and 8 return 0.
REQ-031 Load ids 5,6,7 with 1,2,3; pulse clear_req -> busy=1 for 3 cycles, then ids 5,6,7 read 0.
REQ-032 Write id 5 value 0x55 during busy -> write_err pulse; id 5 reads 0 after clear completes.
REQ-033 Assert reset during the 2nd busy cycle -> busy=0 and all reads 0 without a clock edge; a write after release works normally.
REQ-034 NUM_REGS=8, BASE_ID=24, ID_W=5: write id 31 value 0xA5 -> accepted; write id 0 -> write_err (no wrap onto id 32).
